// File: rtl/lsu_pipe.sv
// Load/store unit: byte-lane steering, sign/zero extension, posted store queue and
// waitrequest handshaking to the data-memory port. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_pipe #(
  parameter int XLEN       = 32,
  parameter int AW         = 32,
  parameter int SQ_DEPTH   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [AW-1:0]     i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  input  logic [4:0]        i_req_rd,
  output logic              o_resp_valid,
  output logic [4:0]        o_resp_rd,
  output logic [XLEN-1:0]   o_resp_data,
  output logic              o_fault,
  output logic              o_busy,
  output logic [2:0]        o_dbg_state,
  output logic [AW-1:0]     o_ldst_addr,
  output logic              o_ldst_rd,
  output logic              o_ldst_wr,
  output logic [XLEN-1:0]   o_ldst_wrdata,
  output logic [XLEN/8-1:0] o_ldst_byte_en,
  input  logic [XLEN-1:0]   i_ldst_rddata,
  input  logic              i_ldst_waitrequest
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, DRAIN, LD_REQ, LD_WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   sq_addr_q [SQ_DEPTH];
  logic [AW-1:0]   sq_addr_d [SQ_DEPTH];
  logic [BW-1:0]   sq_be_q   [SQ_DEPTH];
  logic [BW-1:0]   sq_be_d   [SQ_DEPTH];
  logic [XLEN-1:0] sq_data_q [SQ_DEPTH];
  logic [XLEN-1:0] sq_data_d [SQ_DEPTH];

  logic [AW-1:0]   ld_addr_q, ld_addr_d;
  logic [BW-1:0]   ld_be_q, ld_be_d;
  logic [OW-1:0]   ld_off_q, ld_off_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ldst_rd_q, ldst_rd_d, ldst_wr_q, ldst_wr_d;
  logic [AW-1:0]   ldst_addr_q, ldst_addr_d;
  logic [XLEN-1:0] ldst_wrdata_q, ldst_wrdata_d;
  logic [BW-1:0]   ldst_be_q, ldst_be_d;
  logic            resp_valid_q, resp_valid_d, fault_q, fault_d;
  logic [4:0]      resp_rd_q, resp_rd_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;

  logic            sq_full, sq_empty_d, accept, push, pop;
  logic [OW-1:0]   req_off, req_lo_mask, req_eff_off;
  logic [3:0]      req_bytes;
  logic [BW-1:0]   req_be;
  logic            req_legal, req_misalign, req_fault;
  logic [AW-1:0]   req_line_addr;
  logic [XLEN-1:0] req_wdata_sh, ld_sh, ld_ext;
  logic [PW-1:0]   head;

  // Handshake: a request transfers on a cycle where i_req_valid && o_req_ready;
  // o_req_ready depends only on registered state, never on the request fields.
  assign sq_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign o_req_ready = (state_q == IDLE) && !sq_full;
  assign o_busy      = (state_q != IDLE) || (wr_ptr_q != rd_ptr_q);
  assign o_dbg_state = state_q;

  always_comb begin
    req_off       = i_req_addr[OW-1:0];
    req_bytes     = 4'd1 << i_req_funct3[1:0];
    req_lo_mask   = OW'(req_bytes - 4'd1);
    req_misalign  = (req_off & req_lo_mask) != '0;
    req_eff_off   = req_off & ~req_lo_mask;
    req_be        = BW'((16'h1 << req_bytes) - 16'h1) << req_eff_off;
    req_line_addr = {i_req_addr[AW-1:OW], {OW{1'b0}}};
    req_wdata_sh  = i_req_wdata << {req_eff_off, 3'b000};
    if (i_req_we) begin
      req_legal = (i_req_funct3 == 3'd0) || (i_req_funct3 == 3'd1) ||
                  (i_req_funct3 == 3'd2) || ((XLEN == 64) && (i_req_funct3 == 3'd3));
    end else begin
      req_legal = (i_req_funct3 != 3'd7) &&
                  ((XLEN == 64) || ((i_req_funct3 != 3'd3) && (i_req_funct3 != 3'd6)));
    end
`ifdef LSU_MISALIGN_TRAP_EN
    req_fault = !req_legal || req_misalign;
`else
    req_fault = !req_legal;
`endif
  end

  // Returned word is lane-shifted down, then extended according to the captured funct3.
  always_comb begin
    ld_sh = i_ldst_rddata >> {ld_off_q, 3'b000};
    case (ld_f3_q)
      3'd0:    ld_ext = XLEN'($signed(ld_sh[7:0]));
      3'd1:    ld_ext = XLEN'($signed(ld_sh[15:0]));
      3'd2:    ld_ext = XLEN'($signed(ld_sh[31:0]));
      3'd4:    ld_ext = XLEN'(ld_sh[7:0]);
      3'd5:    ld_ext = XLEN'(ld_sh[15:0]);
      3'd6:    ld_ext = XLEN'(ld_sh[31:0]);
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sq_addr_d    = sq_addr_q;
    sq_be_d      = sq_be_q;
    sq_data_d    = sq_data_q;
    ld_addr_d    = ld_addr_q;
    ld_be_d      = ld_be_q;
    ld_off_d     = ld_off_q;
    ld_f3_d      = ld_f3_q;
    ld_rd_d      = ld_rd_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    accept       = i_req_valid && o_req_ready;
    push         = accept && i_req_we && !req_fault;
    pop          = ldst_wr_q && !i_ldst_waitrequest;
    fault_d      = accept && req_fault;

    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push) begin
      sq_addr_d[wr_ptr_q[PW-1:0]] = req_line_addr;
      sq_be_d[wr_ptr_q[PW-1:0]]   = req_be;
      sq_data_d[wr_ptr_q[PW-1:0]] = req_wdata_sh;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    sq_empty_d = (rd_ptr_d == wr_ptr_d);

    case (state_q)
      IDLE: begin
        if (accept && !i_req_we && !req_fault) begin
          ld_addr_d = req_line_addr;
          ld_be_d   = req_be;
          ld_off_d  = req_eff_off;
          ld_f3_d   = i_req_funct3;
          ld_rd_d   = i_req_rd;
          state_d   = sq_empty_d ? LD_REQ : DRAIN;
        end
      end
      DRAIN:  if (sq_empty_d) state_d = LD_REQ;
      LD_REQ: begin
        if (ldst_rd_q && !i_ldst_waitrequest) begin
          state_d = LD_WAIT;
          cnt_d   = CW'(RD_LATENCY);
        end
      end
      LD_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = ld_rd_q;
          resp_data_d  = ld_ext;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Port outputs are registered, so they are computed from next-cycle state and queue head.
    head          = rd_ptr_d[PW-1:0];
    ldst_rd_d     = 1'b0;
    ldst_wr_d     = 1'b0;
    ldst_addr_d   = '0;
    ldst_wrdata_d = '0;
    ldst_be_d     = '0;
    if (state_d == LD_REQ) begin
      ldst_rd_d   = 1'b1;
      ldst_addr_d = ld_addr_d;
      ldst_be_d   = ld_be_d;
    end else if (((state_d == IDLE) || (state_d == DRAIN)) && !sq_empty_d) begin
      ldst_wr_d     = 1'b1;
      ldst_addr_d   = sq_addr_d[head];
      ldst_be_d     = sq_be_d[head];
      ldst_wrdata_d = sq_data_d[head];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ld_addr_q     <= '0;
      ld_be_q       <= '0;
      ld_off_q      <= '0;
      ld_f3_q       <= '0;
      ld_rd_q       <= '0;
      cnt_q         <= '0;
      ldst_rd_q     <= 1'b0;
      ldst_wr_q     <= 1'b0;
      ldst_addr_q   <= '0;
      ldst_wrdata_q <= '0;
      ldst_be_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_rd_q     <= '0;
      resp_data_q   <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ld_addr_q     <= ld_addr_d;
      ld_be_q       <= ld_be_d;
      ld_off_q      <= ld_off_d;
      ld_f3_q       <= ld_f3_d;
      ld_rd_q       <= ld_rd_d;
      cnt_q         <= cnt_d;
      ldst_rd_q     <= ldst_rd_d;
      ldst_wr_q     <= ldst_wr_d;
      ldst_addr_q   <= ldst_addr_d;
      ldst_wrdata_q <= ldst_wrdata_d;
      ldst_be_q     <= ldst_be_d;
      resp_valid_q  <= resp_valid_d;
      resp_rd_q     <= resp_rd_d;
      resp_data_q   <= resp_data_d;
      fault_q       <= fault_d;
    end
  end

  // Queue storage needs no reset: only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    sq_addr_q <= sq_addr_d;
    sq_be_q   <= sq_be_d;
    sq_data_q <= sq_data_d;
  end

  assign o_ldst_rd      = ldst_rd_q;
  assign o_ldst_wr      = ldst_wr_q;
  assign o_ldst_addr    = ldst_addr_q;
  assign o_ldst_wrdata  = ldst_wrdata_q;
  assign o_ldst_byte_en = ldst_be_q;
  assign o_resp_valid   = resp_valid_q;
  assign o_resp_rd      = resp_rd_q;
  assign o_resp_data    = resp_data_q;
  assign o_fault        = fault_q;
endmodule

// File: doc/lsu_pipe.md
# lsu_pipe

Parameterised load/store unit sitting between the execute stage of the pipelined RISC-V core and the `o_ldst_*` data-memory port. It performs byte-lane steering, sign/zero extension, posted stores through a `SQ_DEPTH`-entry store queue, and full `waitrequest` handshaking. It completes the data-memory path, which the single-cycle-style ldst signals in the core left undriven. It supports `XLEN` of 32 or 64 and a configurable fixed memory read latency.

## Interface
- `XLEN`, 32: data width; legal values 32 or 64.
- `AW`, 32: byte address width.
- `SQ_DEPTH`, 4: store-queue entries; power of 2, ≥2.
- `RD_LATENCY`, 1: cycles from an accepted read to valid `i_ldst_rddata`; ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: request accepted when valid&&ready.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_funct3` in 3: RV encoding. LB/LH/LW/LBU/LHU/SB/SH/SW; LD/LWU/SD only when XLEN=64.
- `i_req_addr` in AW: byte address (rs1+imm, already computed).
- `i_req_wdata` in XLEN: store data, LSB-aligned.
- `i_req_rd` in 5: load destination register.
- `o_resp_valid` out 1: one-cycle load-result pulse; no backpressure.
- `o_resp_rd` out 5: destination register.
- `o_resp_data` out XLEN: extended load result.
- `o_fault` out 1: misaligned-access pulse (see Configuration).
- `o_busy` out 1: state≠IDLE or store queue non-empty.
- `o_ldst_addr` out AW: address with the low log2(XLEN/8) bits cleared.
- `o_ldst_rd` / `o_ldst_wr` out 1: memory read/write strobes.
- `o_ldst_wrdata` out XLEN: lane-shifted store data.
- `o_ldst_byte_en` out XLEN/8: lane mask.
- `i_ldst_rddata` in XLEN: read data.
- `i_ldst_waitrequest` in 1: memory stall.

## Operation
- **FSM states:** IDLE, DRAIN, LD_REQ, LD_WAIT, RESP.
- **Ready:** `o_req_ready` = (state==IDLE) && !sq_full. It is not gated by `i_req_we`. There is no enqueue bypass when the queue is full.
- **Store accept:** writes {lane addr, byte_en, shifted wdata} into the queue tail.
  - offset = addr[log2(XLEN/8)-1:0].
  - byte_en = size_mask << offset, with size_mask 1/3/F/FF for B/H/W/D.
  - wrdata = wdata << (8·offset).
- **Store issue:** the queue head is issued whenever the port is free in IDLE or DRAIN. The head is popped on the cycle `o_ldst_wr` is high and `i_ldst_waitrequest` is low. The next entry may be presented the following cycle (back-to-back).
- **Load accept:** captures funct3, offset and rd. Next state is DRAIN if the queue is non-empty, else LD_REQ. DRAIN exits to LD_REQ when the queue empties. Loads never bypass older stores.
- **LD_REQ:**
  - `o_ldst_rd` is high, with byte_en computed as for stores.
  - Address and control are held stable while `i_ldst_waitrequest` is high.
  - On acceptance, go to LD_WAIT and load a counter with RD_LATENCY.
- **LD_WAIT:** counts down. At zero, capture rddata >> (8·offset), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU; LD is a full pass-through). Go to RESP.
- **RESP:** `o_resp_valid`=1 for one cycle, then IDLE.
- **Illegal funct3** (including 64-bit ops when XLEN=32): the request is accepted and dropped. There is no memory access, no response, and `o_fault` is pulsed.
- **Reset:** queue pointers cleared, state=IDLE. All outputs are 0 except `o_req_ready`=1. Reset mid-transfer aborts immediately: strobes drop and the pending load and queued stores are discarded.

## Timing
- `o_ldst_*` and `o_resp_*` are registered outputs.
- **Load latency**, accept at cycle T with an empty queue and no stall:
  - `o_ldst_rd` at T+1.
  - Data sampled at T+1+RD_LATENCY.
  - `o_resp_valid` at T+2+RD_LATENCY.
  - Each waitrequest cycle adds 1.
- **Store latency:** accept at T with an empty queue → `o_ldst_wr` at T+1.
- **Strobes:** `o_ldst_rd` and `o_ldst_wr` are never high together.
- **Queue full/empty:** distinguished by an extra pointer wrap bit. Pointers wrap modulo SQ_DEPTH.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** an access with offset not a multiple of its size (H odd, W offset%4≠0, D offset≠0) is accepted. It then:
  - causes no memory access and no queue entry;
  - pulses `o_fault` for one cycle at T+1;
  - returns the FSM to IDLE.
- **Undefined:** the offending low offset bits are truncated to the size alignment and the access proceeds. `o_fault` is asserted only for illegal funct3.

## Test plan
- **LW after reset:** XLEN=32, RD_LATENCY=1. LW addr 0x10, rddata 0xDEADBEEF → `o_ldst_rd` at T+1 with addr 0x10 and byte_en 4'hF; `o_resp_valid` at T+3 with data 0xDEADBEEF.
- **LB with sign extension:** LB addr 0x13, rddata 0x80FF_0000 → byte_en 4'h8; resp 0xFFFFFF80. LBU on the same access → 0x00000080.
- **SH with waitrequest:** SH addr 0x22, wdata 0x1234, waitrequest high for 3 cycles → wrdata 0x12340000 and byte_en 4'hC held stable 4 cycles; pop on cycle 4.
- **Queue full then load:** 4 SW back-to-back with waitrequest held high → ready low after the 4th. Release waitrequest, then a LW to the same address → read issues only after all 4 writes; returns the last SW value.
- **Misaligned access:** LW addr 0x6 → with `LSU_MISALIGN_TRAP_EN`: `o_fault`=1, no strobe. Without it: read at addr 0x4, byte_en 4'hF.
- **Reset mid-load:** assert reset during LD_WAIT → next cycle all strobes 0, `o_busy`=0, no `o_resp_valid` follows.
